avalon_pio_bidir: RTL and testbench

//  Parametrised Avalon-MM slave PIO. Successor to the single-bit output-only PIO.

---
 rtl/avalon_pio_bidir_pkg.sv | 15 +
 rtl/avalon_pio_bidir_if.sv | 21 ++
 rtl/avalon_pio_bidir_edge_sync.sv | 42 ++++
 rtl/avalon_pio_bidir.sv | 111 +++++++++++
 tb/tb_avalon_pio_bidir.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_pio_bidir_pkg.sv
// rtl/avalon_pio_bidir_pkg.sv - register map and edge-mode constants for the bidirectional PIO
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_pio_bidir_if.sv
// rtl/avalon_pio_bidir_if.sv - Avalon-MM slave bus bundle for the bidirectional PIO
interface avalon_pio_bidir_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );

endinterface

// File: rtl/avalon_pio_bidir_edge_sync.sv
// rtl/avalon_pio_bidir_edge_sync.sv - 2-flop pad synchroniser plus per-bit edge detector
module pio_edge_sync
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] sync1,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] sync0_q;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] prev_q;

    // Clearing to 0 means a pin held high produces one rising capture after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0_q <= '0;
            sync1_q <= '0;
            prev_q  <= '0;
        end else begin
            sync0_q <= pio_in;
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_pulse = ~sync1_q & prev_q;
            EDGE_ANY:  edge_pulse = sync1_q ^ prev_q;
            default:   edge_pulse = sync1_q & ~prev_q;
        endcase
    end

    assign sync1 = sync1_q;

endmodule

// File: rtl/avalon_pio_bidir.sv
// rtl/avalon_pio_bidir.sv - Avalon-MM PIO with per-bit direction, edge capture and irq
// Optional PIO_BITSET_EN maps OUTSET/OUTCLR at addresses 4/5 for atomic bit set/clear.
module avalon_pio_bidir
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_OUT = '1,
    parameter logic [WIDTH-1:0] RESET_DIR = '0,
    parameter int               EDGE_TYPE = EDGE_RISE
) (
    input  logic                clk,
    input  logic                reset,
    avalon_pio_bidir_if.slave   bus,
    output logic                irq,
    input  logic [WIDTH-1:0]    pio_in,
    output logic [WIDTH-1:0]    pio_out,
    output logic [WIDTH-1:0]    pio_oe
);

    logic             wr_stb;
    logic             rd_stb;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] edge_pulse;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] rmux;
    logic [31:0]      readdata_q, readdata_d;

    assign wr_stb       = bus.chipselect & ~bus.write_n;
    assign rd_stb       = bus.chipselect & ~bus.read_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    pio_edge_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge_sync (
        .clk        (clk),
        .reset      (reset),
        .pio_in     (pio_in),
        .sync1      (sync1),
        .edge_pulse (edge_pulse)
    );

    always_comb begin
        data_d   = data_q;
        dir_d    = dir_q;
        mask_d   = mask_q;
        edge_clr = '0;
        if (wr_stb) begin
            case (bus.address)
                ADDR_DATA:   data_d   = wdata;
                ADDR_DIR:    dir_d    = wdata;
                ADDR_MASK:   mask_d   = wdata;
                ADDR_EDGE:   edge_clr = wdata;
`ifdef PIO_BITSET_EN
                ADDR_OUTSET: data_d   = data_q | wdata;
                ADDR_OUTCLR: data_d   = data_q & ~wdata;
`endif
                default: ;
            endcase
        end
        // A fresh edge in the clearing cycle must not be lost, so the set term wins.
        edge_d = (edge_q & ~edge_clr) | edge_pulse;
    end

    always_comb begin
        rmux = '0;
        case (bus.address)
            ADDR_DATA: rmux = sync1;
            ADDR_DIR:  rmux = dir_q;
            ADDR_MASK: rmux = mask_q;
            ADDR_EDGE: rmux = edge_q;
            default:   rmux = '0;
        endcase
        readdata_d = readdata_q;
        if (rd_stb) begin
            readdata_d            = '0;
            readdata_d[WIDTH-1:0] = rmux;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_OUT;
            dir_q      <= RESET_DIR;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edge_q & mask_q);
    assign pio_out      = data_q;
    assign pio_oe       = dir_q;

endmodule

// File: tb/tb_avalon_pio_bidir.sv
// tb/tb_avalon_pio_bidir.sv - directed vector table, corner sequences and random run against a reference model
module tb_avalon_pio_bidir;
    import avalon_pio_pkg::*;

    localparam int ET = EDGE_RISE;
`ifdef PIO_BITSET_EN
    localparam bit BITSET = 1'b1;
`else
    localparam bit BITSET = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       irq;
    logic [7:0] pio_in;
    logic [7:0] pio_out;
    logic [7:0] pio_oe;

    avalon_pio_bidir_if bus();

    avalon_pio_bidir #(
        .WIDTH     (8),
        .RESET_OUT (8'hFF),
        .RESET_DIR (8'h00),
        .EDGE_TYPE (ET)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq     (irq),
        .pio_in  (pio_in),
        .pio_out (pio_out),
        .pio_oe  (pio_oe)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: visible registers plus the pin values seen at the last four clock edges.
    logic [7:0]  m_data, m_dir, m_mask, m_edge;
    logic [31:0] m_rd;
    logic [7:0]  hist [4];

    typedef struct {
        logic [2:0]  a;
        int          op;     // 0 idle, 1 write, 2 read, 3 strobes low with chipselect low
        logic [31:0] wd;
        logic [7:0]  pins;
        logic [31:0] e_rd;
        logic [7:0]  e_out;
        logic [7:0]  e_oe;
        logic        e_irq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data = 8'hFF;
        m_dir  = 8'h00;
        m_mask = 8'h00;
        m_edge = 8'h00;
        m_rd   = 32'h0;
        for (int i = 0; i < 4; i++) hist[i] = 8'h00;
    endtask

    task automatic model_edge(input logic [2:0] a, input bit wr, input bit rd,
                              input logic [31:0] wd, input logic [7:0] pins);
        logic [7:0] det;
        logic [7:0] clr;
        logic [7:0] w;
        w = wd[7:0];
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = pins;
        // Readable pin value lags the pad by two edges; edges compare it with the edge before.
        case (ET)
            EDGE_FALL: det = ~hist[2] & hist[3];
            EDGE_ANY:  det = hist[2] ^ hist[3];
            default:   det = hist[2] & ~hist[3];
        endcase
        if (rd) begin
            case (a)
                3'd0:    m_rd = {24'h0, hist[2]};
                3'd1:    m_rd = {24'h0, m_dir};
                3'd2:    m_rd = {24'h0, m_mask};
                3'd3:    m_rd = {24'h0, m_edge};
                default: m_rd = 32'h0;
            endcase
        end
        clr = 8'h00;
        if (wr) begin
            case (a)
                3'd0: m_data = w;
                3'd1: m_dir  = w;
                3'd2: m_mask = w;
                3'd3: clr    = w;
                3'd4: if (BITSET) m_data = m_data | w;
                3'd5: if (BITSET) m_data = m_data & ~w;
                default: ;
            endcase
        end
        m_edge = (m_edge & ~clr) | det;
    endtask

    // Entered and left at a falling edge.
    task automatic step(input logic [2:0] a, input int op, input logic [31:0] wd, input logic [7:0] pins);
        bus.address    = a;
        bus.chipselect = (op == 1 || op == 2);
        bus.write_n    = !(op == 1 || op == 3);
        bus.read_n     = !(op == 2 || op == 3);
        bus.writedata  = wd;
        pio_in         = pins;
        @(posedge clk);
        model_edge(a, op == 1, op == 2, wd, pins);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rdata"}, bus.readdata, m_rd);
        check({tag, ".out"}, {24'h0, pio_out}, {24'h0, m_data});
        check({tag, ".oe"}, {24'h0, pio_oe}, {24'h0, m_dir});
        check({tag, ".irq"}, {31'h0, irq}, {31'h0, |(m_edge & m_mask)});
    endtask

    initial begin
        vec_t       vt[$];
        logic [7:0] pins;

        reset          = 1'b1;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        bus.writedata  = 32'h0;
        pio_in         = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset.out", {24'h0, pio_out}, 32'hFF);
        check("reset.oe", {24'h0, pio_oe}, 32'h00);
        check("reset.irq", {31'h0, irq}, 32'h0);
        check("reset.rdata", bus.readdata, 32'h0);
        reset = 1'b0;

        vt.push_back('{3'd0, 2, 32'h0,        8'h00, 32'h00, 8'hFF, 8'h00, 1'b0});
        vt.push_back('{3'd1, 2, 32'h0,        8'h00, 32'h00, 8'hFF, 8'h00, 1'b0});
        vt.push_back('{3'd2, 2, 32'h0,        8'h00, 32'h00, 8'hFF, 8'h00, 1'b0});
        vt.push_back('{3'd3, 2, 32'h0,        8'h00, 32'h00, 8'hFF, 8'h00, 1'b0});
        vt.push_back('{3'd6, 2, 32'h0,        8'h00, 32'h00, 8'hFF, 8'h00, 1'b0});
        vt.push_back('{3'd7, 2, 32'h0,        8'h00, 32'h00, 8'hFF, 8'h00, 1'b0});
        vt.push_back('{3'd0, 1, 32'hFFFF_FFA5, 8'h00, 32'h00, 8'hA5, 8'h00, 1'b0});
        vt.push_back('{3'd1, 1, 32'h0000_000F, 8'h00, 32'h00, 8'hA5, 8'h0F, 1'b0});
        vt.push_back('{3'd1, 2, 32'h0,        8'h00, 32'h0F, 8'hA5, 8'h0F, 1'b0});
        vt.push_back('{3'd0, 0, 32'h0,        8'h00, 32'h0F, 8'hA5, 8'h0F, 1'b0});
        vt.push_back('{3'd0, 3, 32'h0,        8'h00, 32'h0F, 8'hA5, 8'h0F, 1'b0});
        vt.push_back('{3'd4, 1, 32'h5A,       8'h00, 32'h0F, BITSET ? 8'hFF : 8'hA5, 8'h0F, 1'b0});
        vt.push_back('{3'd5, 1, 32'hF0,       8'h00, 32'h0F, BITSET ? 8'h0F : 8'hA5, 8'h0F, 1'b0});
        vt.push_back('{3'd4, 2, 32'h0,        8'h00, 32'h00, BITSET ? 8'h0F : 8'hA5, 8'h0F, 1'b0});
        vt.push_back('{3'd0, 1, 32'h00,       8'h00, 32'h00, 8'h00, 8'h0F, 1'b0});
        vt.push_back('{3'd4, 1, 32'h81,       8'h00, 32'h00, BITSET ? 8'h81 : 8'h00, 8'h0F, 1'b0});
        vt.push_back('{3'd5, 1, 32'h01,       8'h00, 32'h00, BITSET ? 8'h80 : 8'h00, 8'h0F, 1'b0});

        foreach (vt[i]) begin
            step(vt[i].a, vt[i].op, vt[i].wd, vt[i].pins);
            check($sformatf("vec%0d.rdata", i), bus.readdata, vt[i].e_rd);
            check($sformatf("vec%0d.out", i), {24'h0, pio_out}, {24'h0, vt[i].e_out});
            check($sformatf("vec%0d.oe", i), {24'h0, pio_oe}, {24'h0, vt[i].e_oe});
            check($sformatf("vec%0d.irq", i), {31'h0, irq}, {31'h0, vt[i].e_irq});
        end

        // Rising edge on bit 0 becomes readable in EDGE on the third clock after the pin change.
        step(3'd0, 0, 32'h0, 8'h01);
        step(3'd0, 0, 32'h0, 8'h01);
        step(3'd3, 2, 32'h0, 8'h01);
        check("edge3.early", bus.readdata, 32'h00);
        step(3'd3, 2, 32'h0, 8'h01);
        check("edge3.captured", bus.readdata, 32'h01);
        check("edge3.irq_masked", {31'h0, irq}, 32'h0);
        step(3'd2, 1, 32'h01, 8'h01);
        check("edge3.irq_on", {31'h0, irq}, 32'h1);
        step(3'd3, 1, 32'h01, 8'h01);
        check("edge3.irq_cleared", {31'h0, irq}, 32'h0);
        check_model("edge3");

        // Clear of bit 2 lands on the same edge that captures a new rise on bit 2.
        step(3'd0, 0, 32'h0, 8'h05);
        step(3'd0, 0, 32'h0, 8'h05);
        step(3'd3, 1, 32'h04, 8'h05);
        step(3'd3, 2, 32'h0, 8'h05);
        check("setwins.edge", bus.readdata, 32'h04);
        check_model("setwins");

        // Asynchronous reset during a read while irq is high, pins held at 0xFF.
        step(3'd2, 1, 32'hFF, 8'hFF);
        check("prereset.irq", {31'h0, irq}, 32'h1);
        bus.address    = 3'd1;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("asyncrst.out", {24'h0, pio_out}, 32'hFF);
        check("asyncrst.oe", {24'h0, pio_oe}, 32'h00);
        check("asyncrst.irq", {31'h0, irq}, 32'h0);
        check("asyncrst.rdata", bus.readdata, 32'h0);
        model_reset();
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(3'd0, 0, 32'h0, 8'hFF);
        step(3'd0, 0, 32'h0, 8'hFF);
        step(3'd3, 2, 32'h0, 8'hFF);
        check("spurious.early", bus.readdata, 32'h00);
        step(3'd3, 2, 32'h0, 8'hFF);
        check("spurious.edge", bus.readdata, 32'hFF);
        step(3'd0, 2, 32'h0, 8'hFF);
        check("spurious.data", bus.readdata, 32'hFF);
        check_model("postreset");

        pins = 8'hFF;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
            step(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom, pins);
            check_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
